swicth_conf_control_mt: RTL
===========================

// Module: swicth_conf_control_mt
// PURPOSE
//  Parametrised, multi-thread configuration controller for one CGRA switch.
//  Decodes the 64-bit configuration bus and stores per-thread switch configuration words.
//  Round-robins the threads, advancing a per-thread looping PC.
//  Delivers the selected word to the switch through an aligned output pipeline.
//  Beyond the fixed 24-bit/8-thread generation: runtime thread-enable mask, global PC restart,
//  and valid/thread-id sideband outputs.
// PARAMETERS
//  SWICTH_NUMBER  0   switch id matched against the bus target field
//  STAGE          1   extra pipeline stages; output pipe depth = STAGE+3
//  CONF_WIDTH     24  configuration word width (1..29)
//  NUM_THREADS    8   hardware threads (2..256); TID_W = clog2(NUM_THREADS)
//  PC_DEPTH       2   configuration words per thread (2..256); PC_W = clog2(PC_DEPTH)
// PORTS
//  clk                clock               (input)  1
//  rst                async active-high reset (input) 1
//  en_pc_net          network advance enable; gates all thread/PC/pipe progress (input) 1
//  conf_bus_in        configuration bus   (input)  64
//  swicth_conf_out    configuration word to switch (output) CONF_WIDTH
//  swicth_conf_valid  word belongs to an enabled thread (output) 1
//  swicth_thread_out  thread id aligned with swicth_conf_out (output) TID_W
// BEHAVIOUR
//  - Bus fields: [2:0] cmd; [18:3] switch id; [26:19] thread; [34:27] addr; [63:35] data.
//    Thread and addr use their TID_W/PC_W LSBs; data uses its CONF_WIDTH LSBs.
//  - A command is accepted only when the switch id equals SWICTH_NUMBER. Decode is registered:
//    the effect is visible 1 clk after the bus cycle and does not depend on en_pc_net.
//  - Commands:
//    0 NOP.
//    1 SET_MAX: pc_max[thread] <= addr.
//    2 SET_LOOP: pc_loop[thread] <= addr.
//    3 WRITE: mem[{thread,addr}] <= data.
//    4 SET_EN: thr_en[thread] <= data[0].
//    5 RESTART: all PCs <= 0, thread counter <= 0.
//    6,7: ignored.
//  - Thread counter tidx: 0..NUM_THREADS-1. Increments on en_pc_net; wraps to 0 after NUM_THREADS-1.
//  - PCs: pc[tidx] advances only when en_pc_net=1 and thr_en[tidx]=1.
//    If pc >= pc_max: pc <= pc_loop. Otherwise: pc <= pc+1. Other threads' PCs hold.
//  - Memory: NUM_THREADS*PC_DEPTH x CONF_WIDTH, synchronous read.
//    raddr = {tidx, pc[tidx]}; read enabled by en_pc_net.
//    Write and read to the same address in one clk: the read returns the old data.
//  - Disabled thread: its read stage injects all-zero conf with valid=0; the thread id still propagates.
//  - Output: word, valid and thread id travel through STAGE+3 registers enabled by en_pc_net.
//    Total latency is STAGE+4 enabled cycles from thread selection to swicth_conf_out.
//    en_pc_net=0 freezes the whole datapath.
//  - RESTART at the same clk as en_pc_net: RESTART wins for PCs and tidx.
//    Words already in the pipe still drain.
//  - SET_MAX/SET_LOOP write while that thread advances: the new value is used from the next advance.
//  - Reset (async, any time):
//    pc, tidx, pc_max, pc_loop = 0; thr_en = all 1.
//    Pipe regs, swicth_conf_out, swicth_conf_valid, swicth_thread_out = 0.
//    Memory contents are not reset.
// STRUCTURE
//  - Shared package swicth_conf_pkg: cmd encodings and bus field offsets/widths (CMD_*, F_SWID_LSB, etc.).
//  - Sub-module swicth_conf_pc #(PC_W): one PC with max/loop/restart, instantiated NUM_THREADS times.
//  - Reuse existing memory and reg_pipe blocks. reg_pipe needs async reset; add it if absent.
// TESTING
//  1. Reset: after rst pulse, all outputs 0; tidx 0; thr_en all 1.
//  2. Fill/loop: write thread 3 addr0=0xA5A5A5, addr1=0x5A5A5A; max=1, loop=0; hold en_pc_net=1.
//     -> thread-3 slots alternate A5A5A5/5A5A5A, valid=1, thread_out=3, latency STAGE+4.
//  3. Switch-id filter: WRITE with switch id SWICTH_NUMBER+1 -> memory and PCs unchanged.
//  4. Thread disable: SET_EN thread 2 data0=0 -> thread-2 slots show conf 0, valid 0.
//     Thread-2 PC frozen; re-enable resumes at the saved PC.
//  5. Restart/freeze: RESTART mid-run -> next selected thread is 0 at pc 0.
//     en_pc_net=0 for 5 clk -> outputs constant; resuming gives no skipped or duplicated slot.
//  6. Async reset mid-run: assert rst between clock edges -> outputs 0 immediately, before the next edge.

Source files
------------

// File: rtl/swicth_conf_pkg.sv
// swicth_conf_pkg: command encodings and configuration-bus field layout
package swicth_conf_pkg;
  typedef enum logic [2:0] {
    CMD_NOP      = 3'd0,
    CMD_SET_MAX  = 3'd1,
    CMD_SET_LOOP = 3'd2,
    CMD_WRITE    = 3'd3,
    CMD_SET_EN   = 3'd4,
    CMD_RESTART  = 3'd5
  } cmd_e;
  localparam int F_CMD_LSB  = 0;
  localparam int F_CMD_W    = 3;
  localparam int F_SWID_LSB = 3;
  localparam int F_SWID_W   = 16;
  localparam int F_THR_LSB  = 19;
  localparam int F_ADDR_LSB = 27;
  localparam int F_DATA_LSB = 35;
endpackage

// File: rtl/reg_pipe.sv
// reg_pipe: enabled register delay line with asynchronous reset
module reg_pipe #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [DEPTH-1:0][W-1:0] q;
  // Shifting the concatenation drops the oldest stage and works for DEPTH == 1
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (en_i) q <= (DEPTH*W)'({q, d_i});
  assign q_o = q[DEPTH-1];
endmodule

// File: rtl/swicth_conf_pc.sv
// swicth_conf_pc: one thread's looping PC with its max/loop bounds and restart
module swicth_conf_pc #(
  parameter int PC_W = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            restart_i,
  input  logic            adv_i,
  input  logic            set_max_i,
  input  logic            set_loop_i,
  input  logic [PC_W-1:0] addr_i,
  output logic [PC_W-1:0] pc_o
);
  logic [PC_W-1:0] pc_d, pc_q, max_d, max_q, loop_d, loop_q;
  always_comb begin
    pc_d   = restart_i ? '0 : !adv_i ? pc_q : pc_q >= max_q ? loop_q : pc_q + 1'b1;
    max_d  = set_max_i ? addr_i : max_q;
    loop_d = set_loop_i ? addr_i : loop_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc_q   <= '0;
      max_q  <= '0;
      loop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      max_q  <= max_d;
      loop_q <= loop_d;
    end
  assign pc_o = pc_q;
endmodule

// File: rtl/sync_ram.sv
// sync_ram: simple dual-port RAM, synchronous read returning old data on a same-address write
module sync_ram #(
  parameter int AW = 1,
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end
endmodule

// File: rtl/swicth_conf_control_mt.sv
// swicth_conf_control_mt: multi-thread switch configuration store with round-robin thread/PC
// sequencing and an aligned word/valid/thread-id output pipeline
module swicth_conf_control_mt
  import swicth_conf_pkg::*;
#(
  parameter int SWICTH_NUMBER = 0,
  parameter int STAGE         = 1,
  parameter int CONF_WIDTH    = 24,
  parameter int NUM_THREADS   = 8,
  parameter int PC_DEPTH      = 2,
  localparam int TID_W        = $clog2(NUM_THREADS),
  localparam int PC_W         = $clog2(PC_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_pc_net,
  input  logic [63:0]           conf_bus_in,
  output logic [CONF_WIDTH-1:0] swicth_conf_out,
  output logic                  swicth_conf_valid,
  output logic [TID_W-1:0]      swicth_thread_out
);
  logic [2:0]                       cmd;
  logic                             hit, restart, rd_vld_q, unused_bus;
  logic [TID_W-1:0]                 thr, tidx_d, tidx_q, rd_tid_q;
  logic [PC_W-1:0]                  addr;
  logic [CONF_WIDTH-1:0]            data, rdata, rd_conf;
  logic [NUM_THREADS-1:0]           thr_en_d, thr_en_q;
  logic [NUM_THREADS-1:0][PC_W-1:0] pc;
  assign cmd        = conf_bus_in[F_CMD_LSB +: F_CMD_W];
  assign hit        = conf_bus_in[F_SWID_LSB +: F_SWID_W] == F_SWID_W'(SWICTH_NUMBER);
  assign thr        = conf_bus_in[F_THR_LSB +: TID_W];
  assign addr       = conf_bus_in[F_ADDR_LSB +: PC_W];
  assign data       = conf_bus_in[F_DATA_LSB +: CONF_WIDTH];
  assign restart    = hit && cmd == CMD_RESTART;
  assign unused_bus = ^conf_bus_in;
  always_comb begin
    tidx_d   = restart ? '0 : !en_pc_net ? tidx_q : tidx_q == TID_W'(NUM_THREADS-1) ? '0 : tidx_q + 1'b1;
    thr_en_d = thr_en_q;
    if (hit && cmd == CMD_SET_EN) thr_en_d[thr] = data[0];
  end
  // Read stage: thread id and enable captured alongside the synchronous RAM read
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tidx_q   <= '0;
      thr_en_q <= '1;
      rd_tid_q <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      tidx_q   <= tidx_d;
      thr_en_q <= thr_en_d;
      if (en_pc_net) begin
        rd_tid_q <= tidx_q;
        rd_vld_q <= thr_en_q[tidx_q];
      end
    end
  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thr
    logic sel;
    assign sel = hit && thr == TID_W'(t);
    swicth_conf_pc #(.PC_W(PC_W)) u_pc (
      .clk       (clk),
      .rst       (rst),
      .restart_i (restart),
      .adv_i     (en_pc_net && tidx_q == TID_W'(t) && thr_en_q[t]),
      .set_max_i (sel && cmd == CMD_SET_MAX),
      .set_loop_i(sel && cmd == CMD_SET_LOOP),
      .addr_i    (addr),
      .pc_o      (pc[t])
    );
  end
  sync_ram #(.AW(TID_W+PC_W), .DW(CONF_WIDTH)) u_mem (
    .clk    (clk),
    .we_i   (hit && cmd == CMD_WRITE),
    .waddr_i({thr, addr}),
    .wdata_i(data),
    .re_i   (en_pc_net),
    .raddr_i({tidx_q, pc[tidx_q]}),
    .rdata_o(rdata)
  );
  assign rd_conf = rd_vld_q ? rdata : '0;
  reg_pipe #(.W(CONF_WIDTH+1+TID_W), .DEPTH(STAGE+3)) u_pipe (
    .clk (clk),
    .rst (rst),
    .en_i(en_pc_net),
    .d_i ({rd_conf, rd_vld_q, rd_tid_q}),
    .q_o ({swicth_conf_out, swicth_conf_valid, swicth_thread_out})
  );
endmodule
